dmem_wbuf: RTL and testbench

DMEM_WBUF -- requirements
Module: dmem_wbuf

---
 rtl/dmem_wbuf.sv | 151 +++++++++++++++
 tb/tb_dmem_wbuf.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_wbuf.sv
// Data memory with a shared write buffer for a dual-issue ODD/EVEN pipeline.
// Define DMEM_ALIGN_CHK_EN to add the sticky misalign flag and drop unaligned stores.
module dmem_wbuf #(
  parameter int DEPTH = 64,
  parameter int WBUF  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwritemODD,
  input  logic [31:0] aluoutmODD,
  input  logic [31:0] writedatamODD,
  output logic [31:0] readdatamODD,
  input  logic        memwritemEVEN,
  input  logic [31:0] aluoutmEVEN,
  input  logic [31:0] writedatamEVEN,
  output logic [31:0] readdatamEVEN,
  output logic        memstall
`ifdef DMEM_ALIGN_CHK_EN
  ,
  output logic        misalign
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(WBUF);
  localparam int CW = PW + 1;

  typedef logic [AW-1:0] idx_t;

  logic [31:0]   ram     [DEPTH];
  idx_t          buf_idx [WBUF];
  logic [31:0]   buf_dat [WBUF];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  idx_t          odd_idx;
  idx_t          even_idx;
  logic          odd_ok;
  logic          even_ok;
  logic          odd_en;
  logic          even_en;
  logic          drain;
  logic [PW-1:0] tail_even;
  logic [PW-1:0] tail_next;
  logic [CW-1:0] count_next;
  logic          odd_hit;
  logic          even_hit;
  logic [31:0]   odd_fwd;
  logic [31:0]   even_fwd;
  logic          unused;

  assign odd_idx  = aluoutmODD[AW+1:2];
  assign even_idx = aluoutmEVEN[AW+1:2];
  assign unused   = ^{aluoutmODD[31:AW+2], aluoutmODD[1:0],
                      aluoutmEVEN[31:AW+2], aluoutmEVEN[1:0]};

`ifdef DMEM_ALIGN_CHK_EN
  assign odd_ok  = (aluoutmODD[1:0] == 2'b00);
  assign even_ok = (aluoutmEVEN[1:0] == 2'b00);
`else
  assign odd_ok  = 1'b1;
  assign even_ok = 1'b1;
`endif

  assign odd_en     = memwritemODD & ~memstall & odd_ok;
  assign even_en    = memwritemEVEN & ~memstall & even_ok;
  assign drain      = (count != '0);
  assign tail_even  = tail + PW'(odd_en);
  assign tail_next  = tail_even + PW'(even_en);
  assign count_next = count + CW'(odd_en) + CW'(even_en) - CW'(drain);

  // Youngest live entry wins; the draining head stays live this cycle.
  always_comb begin
    odd_hit  = 1'b0;
    even_hit = 1'b0;
    odd_fwd  = '0;
    even_fwd = '0;
    for (int i = 0; i < WBUF; i++) begin
      if (CW'(i) < count) begin
        if (buf_idx[head + PW'(i)] == odd_idx) begin
          odd_hit = 1'b1;
          odd_fwd = buf_dat[head + PW'(i)];
        end
        if (buf_idx[head + PW'(i)] == even_idx) begin
          even_hit = 1'b1;
          even_fwd = buf_dat[head + PW'(i)];
        end
      end
    end
  end

  // Read mux: same-cycle ODD store beats the buffer for EVEN.
  always_comb begin
    readdatamODD  = odd_hit ? odd_fwd : ram[odd_idx];
    readdatamEVEN = even_hit ? even_fwd : ram[even_idx];
    if (odd_en && (odd_idx == even_idx)) begin
      readdatamEVEN = writedatamODD;
    end
  end

  // Pointer, occupancy and stall registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      memstall <= 1'b0;
    end else begin
      head     <= head + PW'(drain);
      tail     <= tail_next;
      count    <= count_next;
      memstall <= (count_next > CW'(WBUF - 2));
    end
  end

  // Enqueue ODD before EVEN so EVEN lands in RAM last.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (odd_en) begin
        buf_idx[tail] <= odd_idx;
        buf_dat[tail] <= writedatamODD;
      end
      if (even_en) begin
        buf_idx[tail_even] <= even_idx;
        buf_dat[tail_even] <= writedatamEVEN;
      end
    end
  end

  // Single RAM write port fed by the buffer head.
  always_ff @(posedge clk) begin
    if (!reset && drain) begin
      ram[buf_idx[head]] <= buf_dat[head];
    end
  end

`ifdef DMEM_ALIGN_CHK_EN
  // Sticky flag for any accepted unaligned store.
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign <= 1'b0;
    end else if (~memstall &
                 ((memwritemODD & ~odd_ok) |
                  (memwritemEVEN & ~even_ok))) begin
      misalign <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_wbuf.sv
// Self-checking bench for dmem_wbuf against a queue-based memory model.
// Honours DMEM_ALIGN_CHK_EN when the design is built with it.
module tb_dmem_wbuf;

  localparam int DEPTH = 64;
  localparam int WBUF  = 4;
  localparam int AW    = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        reset;
  logic        memwritemODD;
  logic [31:0] aluoutmODD;
  logic [31:0] writedatamODD;
  logic [31:0] readdatamODD;
  logic        memwritemEVEN;
  logic [31:0] aluoutmEVEN;
  logic [31:0] writedatamEVEN;
  logic [31:0] readdatamEVEN;
  logic        memstall;
`ifdef DMEM_ALIGN_CHK_EN
  logic        misalign;
`endif

  dmem_wbuf #(.DEPTH(DEPTH), .WBUF(WBUF)) dut (
    .clk            (clk),
    .reset          (reset),
    .memwritemODD   (memwritemODD),
    .aluoutmODD     (aluoutmODD),
    .writedatamODD  (writedatamODD),
    .readdatamODD   (readdatamODD),
    .memwritemEVEN  (memwritemEVEN),
    .aluoutmEVEN    (aluoutmEVEN),
    .writedatamEVEN (writedatamEVEN),
    .readdatamEVEN  (readdatamEVEN),
    .memstall       (memstall)
`ifdef DMEM_ALIGN_CHK_EN
    ,
    .misalign       (misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m [DEPTH];
  bit          known [DEPTH];
  bit          stall_m;
  bit          mis_m;
  int          checks;
  int          failures;
  logic [31:0] ro_s;
  logic [31:0] re_s;
  logic [31:0] old_a;
  logic [31:0] old_b;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit aligned(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHK_EN
    return (a[1:0] == 2'b00);
`else
    return 1'b1;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  function automatic bit model_read(input int idx, output logic [31:0] d);
    d = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].idx == idx) begin
        d = q[i].d;
        return 1'b1;
      end
    end
    if (known[idx]) begin
      d = m[idx];
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] rnd_addr(input int idx);
    logic [31:0] a;
    a = 32'(idx) << 2;
`ifndef DMEM_ALIGN_CHK_EN
    a[1:0] = 2'($urandom_range(0, 3));
`endif
    return a;
  endfunction

  task automatic step(input bit rst,
                      input bit wo, input logic [31:0] ao,
                      input logic [31:0] dod,
                      input bit we, input logic [31:0] ae,
                      input logic [31:0] dev);
    logic [31:0] e;
    int          io;
    int          ie;
    bit          acc_o;
    ent_t        en;
    io = widx(ao);
    ie = widx(ae);
    reset          = rst;
    memwritemODD   = wo;
    aluoutmODD     = ao;
    writedatamODD  = dod;
    memwritemEVEN  = we;
    aluoutmEVEN    = ae;
    writedatamEVEN = dev;
    #1;
    ro_s = readdatamODD;
    re_s = readdatamEVEN;
    if (model_read(io, e)) chk("rd_odd", readdatamODD, e);
    acc_o = wo && !stall_m && aligned(ao);
    if (acc_o && io == ie) chk("rd_even_fwd", readdatamEVEN, dod);
    else if (model_read(ie, e)) chk("rd_even", readdatamEVEN, e);
    @(posedge clk);
    if (rst) begin
      q.delete();
      stall_m = 1'b0;
      mis_m   = 1'b0;
    end else begin
      if (q.size() > 0) begin
        en = q.pop_front();
        m[en.idx]     = en.d;
        known[en.idx] = 1'b1;
      end
      if (!stall_m) begin
        if (wo) begin
          if (aligned(ao)) q.push_back('{io, dod});
          else mis_m = 1'b1;
        end
        if (we) begin
          if (aligned(ae)) q.push_back('{ie, dev});
          else mis_m = 1'b1;
        end
      end
      stall_m = (q.size() > WBUF - 2);
    end
    @(negedge clk);
    chk("memstall", 32'(memstall), 32'(stall_m));
`ifdef DMEM_ALIGN_CHK_EN
    chk("misalign", 32'(misalign), 32'(mis_m));
`endif
  endtask

  task automatic idle(input logic [31:0] ao, input logic [31:0] ae);
    step(1'b0, 1'b0, ao, 32'h0, 1'b0, ae, 32'h0);
  endtask

  initial begin
    int w;
    checks   = 0;
    failures = 0;
    stall_m  = 1'b0;
    mis_m    = 1'b0;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("reset_stall", 32'(memstall), 32'h0);

    step(1'b0, 1'b1, 32'h10, 32'h11, 1'b0, 32'h0, 32'h0);
    idle(32'h10, 32'h0);
    chk("odd_fwd_next", ro_s, 32'h11);
    idle(32'h10, 32'h0);
    chk("odd_ram_after", ro_s, 32'h11);

    step(1'b0, 1'b1, 32'h20, 32'hAA, 1'b0, 32'h20, 32'h0);
    chk("even_same_cycle_fwd", re_s, 32'hAA);
    idle(32'h0, 32'h0);

    step(1'b0, 1'b1, 32'h30, 32'h1, 1'b1, 32'h30, 32'h2);
    idle(32'h30, 32'h30);
    idle(32'h30, 32'h30);
    idle(32'h30, 32'h30);
    chk("same_word_even_wins", ro_s, 32'h2);

    w = 0;
    while (w < DEPTH) begin
      if (!stall_m) begin
        step(1'b0, 1'b1, 32'(w) << 2, $urandom,
             1'b1, 32'(w + 1) << 2, $urandom);
        w += 2;
      end else begin
        idle(32'h0, 32'h0);
      end
    end
    for (int i = 0; i < 4; i++) idle(32'h0, 32'h4);

    step(1'b0, 1'b1, 32'h80, 32'hB0, 1'b1, 32'h84, 32'hB1);
    chk("dual1_stall", 32'(memstall), 32'h0);
    step(1'b0, 1'b1, 32'h88, 32'hB2, 1'b1, 32'h8C, 32'hB3);
    chk("dual2_stall", 32'(memstall), 32'h1);
    old_a = m[widx(32'h90)];
    old_b = m[widx(32'h94)];
    step(1'b0, 1'b1, 32'h90, 32'hB4, 1'b1, 32'h94, 32'hB5);
    chk("dual3_stall_drop", 32'(memstall), 32'h0);
    for (int i = 0; i < 4; i++) idle(32'h90, 32'h94);
    chk("ignored_odd", ro_s, old_a);
    chk("ignored_even", re_s, old_b);

    step(1'b0, 1'b1, 32'hA0, 32'hC0, 1'b1, 32'hA4, 32'hC1);
    old_a = m[widx(32'hA4)];
    old_b = m[widx(32'hA8)];
    step(1'b0, 1'b1, 32'hA8, 32'hC2, 1'b1, 32'hAC, 32'hC3);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("rst_mid_stall", 32'(memstall), 32'h0);
    idle(32'hA4, 32'hA8);
    chk("rst_drop_a4", ro_s, old_a);
    chk("rst_drop_a8", re_s, old_b);
    idle(32'hA4, 32'hA8);

`ifdef DMEM_ALIGN_CHK_EN
    old_a = m[widx(32'h40)];
    step(1'b0, 1'b1, 32'h42, 32'hDEAD, 1'b0, 32'h0, 32'h0);
    chk("misalign_set", 32'(misalign), 32'h1);
    idle(32'h40, 32'h0);
    idle(32'h40, 32'h0);
    chk("misalign_sticky", 32'(misalign), 32'h1);
    chk("misalign_ram", ro_s, old_a);
`endif

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0),
           1'($urandom_range(0, 1)), rnd_addr($urandom_range(0, 7)),
           $urandom,
           1'($urandom_range(0, 1)), rnd_addr($urandom_range(0, 7)),
           $urandom);
    end
    for (int i = 0; i < 8; i++) begin
      idle(rnd_addr(i), rnd_addr(7 - i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
